// File: rtl/tlc_pkg.sv
// Shared traffic-light definitions used by the request conditioner and the light FSM.
package tlc_pkg;

  typedef enum logic [1:0] {
    LT_GREEN  = 2'd0,
    LT_YELLOW = 2'd1,
    LT_RED    = 2'd2
  } light_t;

  function automatic logic is_green(input logic [1:0] code);
    return code == LT_GREEN;
  endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser followed by a stability counter for one vehicle sensor.
module tlc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pres
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             pres_q, pres_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    pres_d = pres_q;
    cnt_d  = '0;
    if (sync2_q != pres_q) begin
      if (cnt_q == CNT_LAST) begin
        pres_d = ~pres_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pres_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pres_q  <= pres_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pres = pres_q;

endmodule

// File: rtl/tlc_request_conditioner.sv
// Conditions raw sensors into the light FSM hold inputs; green-time fairness cap
// is compiled in with TLC_MAXGREEN_EN.
module tlc_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GREEN       = 8,
  parameter int MAX_GREEN       = 32,
  parameter int CNT_W           = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a_raw,
  input  logic       sensor_b_raw,
  input  logic [1:0] l_a,
  input  logic [1:0] l_b,
  output logic       inp_a,
  output logic       inp_b,
  output logic       req_a,
  output logic       req_b
);
  import tlc_pkg::*;

`ifdef TLC_MAXGREEN_EN
  localparam logic MAXGREEN_EN = 1'b1;
`else
  localparam logic MAXGREEN_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] TMR_SAT = '1;

  logic             pres_a, pres_b;
  logic             green_a, green_b;
  logic             req_a_q, req_a_d, req_b_q, req_b_d;
  logic             prev_green_a_q, prev_green_b_q;
  logic [CNT_W-1:0] timer_q, timer_d, timer_s;
  logic             hold_a_s, hold_b_s;

  tlc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
    .clk(clk), .reset(reset), .raw(sensor_a_raw), .pres(pres_a)
  );

  tlc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
    .clk(clk), .reset(reset), .raw(sensor_b_raw), .pres(pres_b)
  );

  assign green_a = is_green(l_a);
  assign green_b = is_green(l_b);

  // The timer reads as 0 on the very cycle the green pattern changes, so the first green cycle counts as 0.
  always_comb begin
    timer_s = timer_q;
    timer_d = '0;
    req_a_d = req_a_q;
    req_b_d = req_b_q;
    if ((green_a != prev_green_a_q) || (green_b != prev_green_b_q)) begin
      timer_s = '0;
    end else begin
      timer_s = timer_q;
    end
    if (green_a || green_b) begin
      timer_d = (timer_s == TMR_SAT) ? TMR_SAT : timer_s + CNT_W'(1);
    end else begin
      timer_d = '0;
    end
    if (green_a) begin
      req_a_d = 1'b0;
    end else if (pres_a) begin
      req_a_d = 1'b1;
    end else begin
      req_a_d = req_a_q;
    end
    if (green_b) begin
      req_b_d = 1'b0;
    end else if (pres_b) begin
      req_b_d = 1'b1;
    end else begin
      req_b_d = req_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_a_q        <= 1'b0;
      req_b_q        <= 1'b0;
      prev_green_a_q <= 1'b0;
      prev_green_b_q <= 1'b0;
      timer_q        <= '0;
    end else begin
      req_a_q        <= req_a_d;
      req_b_q        <= req_b_d;
      prev_green_a_q <= green_a;
      prev_green_b_q <= green_b;
      timer_q        <= timer_d;
    end
  end

  // Traffic keeps its green unless the cross street waits; with the cap, only until MAX_GREEN.
  always_comb begin
    hold_a_s = pres_a & (~req_b_q | (MAXGREEN_EN & (timer_s < MAX_T)));
    hold_b_s = pres_b & (~req_a_q | (MAXGREEN_EN & (timer_s < MAX_T)));
    inp_a    = 1'b0;
    inp_b    = 1'b0;
    req_a    = 1'b0;
    req_b    = 1'b0;
    if (reset) begin
      inp_a = 1'b0;
      inp_b = 1'b0;
    end else if (green_a && green_b) begin
      inp_a = 1'b0;
      inp_b = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
    end else begin
      inp_a = green_a & ((timer_s < MIN_T) | hold_a_s);
      inp_b = green_b & ((timer_s < MIN_T) | hold_b_s);
      req_a = req_a_q & ~green_a;
      req_b = req_b_q & ~green_b;
    end
  end

endmodule
